player_sprite_renderer: RTL and testbench

PLAYER_SPRITE_RENDERER -- requirements
Module: player_sprite_renderer

---
 rtl/player_sprite_renderer_pkg.sv | 33 +++
 rtl/player_sprite_renderer_hit.sv | 22 ++
 rtl/player_sprite_renderer.sv | 138 +++++++++++++
 tb/tb_player_sprite_renderer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_renderer_pkg.sv
// Shared types and constants for the player sprite renderer: FSM states,
// move directions, RGB565 colours and playfield geometry.
package player_sprite_renderer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MOVE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [15:0] COLOR_SPRITE = 16'hF800;
    localparam logic [15:0] COLOR_WALL   = 16'h07E0;
    localparam logic [15:0] COLOR_BG     = 16'h0000;

    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int WALL_T   = 2;

    // Saturate an 8-bit candidate position into [lo, hi]; the result always fits 7 bits.
    function automatic logic [6:0] clamp7(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return 7'((v < lo) ? lo : ((v > hi) ? hi : v));
    endfunction

endpackage

// File: rtl/player_sprite_renderer_hit.sv
// Combinational test of whether pixel (x,y) lies inside the sprite box
// anchored at (player_x, player_y); compares are widened to avoid 7-bit wrap.
module sprite_hit_test #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic [6:0] x,
    input  logic [6:0] y,
    input  logic [6:0] player_x,
    input  logic [6:0] player_y,
    output logic       hit
);
    logic [7:0] x8, y8, px8, py8;

    assign x8  = {1'b0, x};
    assign y8  = {1'b0, y};
    assign px8 = {1'b0, player_x};
    assign py8 = {1'b0, player_y};

    assign hit = (x8 >= px8) && (x8 < px8 + 8'(SPRITE_W)) &&
                 (y8 >= py8) && (y8 < py8 + 8'(SPRITE_H));
endmodule

// File: rtl/player_sprite_renderer.sv
// Player sprite: button-driven one-pixel moves paced by move_tick with a
// tick-counted cooldown, plus a registered per-pixel colour lookup.
module player_sprite_renderer #(
    parameter int SPRITE_W       = 8,
    parameter int SPRITE_H       = 8,
    parameter int COOLDOWN_TICKS = 3,
    parameter int START_X        = 44,
    parameter int START_Y        = 28
) (
    input  logic        my_clock,
    input  logic        reset,
    input  logic        move_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [6:0]  x,
    input  logic [6:0]  y,
    output logic [15:0] oled_data,
    output logic [6:0]  player_x,
    output logic [6:0]  player_y,
    output logic        moving
);
    import player_sprite_renderer_pkg::*;

    localparam int CNT_W = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);
    localparam logic [7:0] X_MIN = 8'(WALL_T);
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - WALL_T - SPRITE_W);
    localparam logic [7:0] Y_MIN = 8'(WALL_T);
    localparam logic [7:0] Y_MAX = 8'(SCREEN_H - WALL_T - SPRITE_H);

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         player_x_q, player_x_d;
    logic [6:0]         player_y_q, player_y_d;
    logic [15:0]        oled_q, oled_d;
    logic               moving_q, moving_d;
    logic [7:0]         step_x, step_y;
    logic               hit, off_screen, in_wall;

    sprite_hit_test #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_hit (
        .x        (x),
        .y        (y),
        .player_x (player_x_q),
        .player_y (player_y_q),
        .hit      (hit)
    );

    assign off_screen = (x >= 7'(SCREEN_W)) || (y >= 7'(SCREEN_H));
    assign in_wall    = (x < 7'(WALL_T)) || (x >= 7'(SCREEN_W - WALL_T)) ||
                        (y < 7'(WALL_T)) || (y >= 7'(SCREEN_H - WALL_T));

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        player_x_d = player_x_q;
        player_y_d = player_y_q;

        // One-pixel step at 8 bits so the clamp sees the true value.
        step_x = {1'b0, player_x_q};
        step_y = {1'b0, player_y_q};
        case (dir_q)
            DIR_UP:    step_y = {1'b0, player_y_q} - 8'd1;
            DIR_DOWN:  step_y = {1'b0, player_y_q} + 8'd1;
            DIR_LEFT:  step_x = {1'b0, player_x_q} - 8'd1;
            DIR_RIGHT: step_x = {1'b0, player_x_q} + 8'd1;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (move_tick && (btn_up || btn_down || btn_left || btn_right)) begin
                    dir_d   = btn_up   ? DIR_UP   :
                              btn_down ? DIR_DOWN :
                              btn_left ? DIR_LEFT : DIR_RIGHT;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                player_x_d = clamp7(step_x, X_MIN, X_MAX);
                player_y_d = clamp7(step_y, Y_MIN, Y_MAX);
                cnt_d      = '0;
                state_d    = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (move_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(COOLDOWN_TICKS)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        moving_d = (state_d != ST_IDLE);

        // Off-screen coordinates override everything, including the sprite.
        if (off_screen) begin
            oled_d = COLOR_BG;
        end else if (hit) begin
            oled_d = COLOR_SPRITE;
        end else if (in_wall) begin
            oled_d = COLOR_WALL;
        end else begin
            oled_d = COLOR_BG;
        end
    end

    always_ff @(posedge my_clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_UP;
            cnt_q      <= '0;
            player_x_q <= 7'(START_X);
            player_y_q <= 7'(START_Y);
            oled_q     <= COLOR_BG;
            moving_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            player_x_q <= player_x_d;
            player_y_q <= player_y_d;
            oled_q     <= oled_d;
            moving_q   <= moving_d;
        end
    end

    assign oled_data = oled_q;
    assign player_x  = player_x_q;
    assign player_y  = player_y_q;
    assign moving    = moving_q;
endmodule

// File: tb/tb_player_sprite_renderer.sv
// Scoreboard bench for player_sprite_renderer: each driven cycle pushes the
// reference model's expected post-edge outputs; a monitor pops and compares.
module tb_player_sprite_renderer;
    localparam int SW = 8;
    localparam int SH = 8;
    localparam int CD = 3;
    localparam int SX = 44;
    localparam int SY = 28;

    logic        my_clock = 1'b0;
    logic        reset, move_tick, btn_up, btn_down, btn_left, btn_right;
    logic [6:0]  x, y;
    logic [15:0] oled_data;
    logic [6:0]  player_x, player_y;
    logic        moving;

    player_sprite_renderer #(
        .SPRITE_W(SW), .SPRITE_H(SH), .COOLDOWN_TICKS(CD), .START_X(SX), .START_Y(SY)
    ) dut (
        .my_clock  (my_clock),
        .reset     (reset),
        .move_tick (move_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .x         (x),
        .y         (y),
        .oled_data (oled_data),
        .player_x  (player_x),
        .player_y  (player_y),
        .moving    (moving)
    );

    always #5 my_clock = ~my_clock;

    typedef struct {
        int oled;
        int px;
        int py;
        int mv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position, a pending move direction (-1 = none) and
    // the number of ticks still to wait before buttons are honoured again.
    int m_px = SX, m_py = SY, m_pending = -1, m_ticks_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic int colour(int xi, int yi, int px, int py);
        if (xi >= 96 || yi >= 64) return 32'h0000;
        if (xi >= px && xi < px + SW && yi >= py && yi < py + SH) return 32'hF800;
        if (xi < 2 || xi >= 94 || yi < 2 || yi >= 62) return 32'h07E0;
        return 32'h0000;
    endfunction

    task automatic model_and_push();
        exp_t e;
        e.oled = reset ? 0 : colour(int'(x), int'(y), m_px, m_py);
        if (reset) begin
            m_px = SX; m_py = SY; m_pending = -1; m_ticks_left = 0;
        end else if (m_pending >= 0) begin
            case (m_pending)
                0: m_py = (m_py - 1 < 2) ? 2 : m_py - 1;
                1: m_py = (m_py + 1 > 62 - SH) ? 62 - SH : m_py + 1;
                2: m_px = (m_px - 1 < 2) ? 2 : m_px - 1;
                default: m_px = (m_px + 1 > 94 - SW) ? 94 - SW : m_px + 1;
            endcase
            m_pending    = -1;
            m_ticks_left = CD;
        end else if (m_ticks_left > 0) begin
            if (move_tick) m_ticks_left--;
        end else if (move_tick && (btn_up || btn_down || btn_left || btn_right)) begin
            m_pending = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : 3;
        end
        e.px = m_px;
        e.py = m_py;
        e.mv = (m_pending >= 0 || m_ticks_left > 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit tk, input bit u, input bit d,
                        input bit l, input bit rt, input int xi, input int yi);
        @(negedge my_clock);
        reset = r; move_tick = tk;
        btn_up = u; btn_down = d; btn_left = l; btn_right = rt;
        x = 7'(xi); y = 7'(yi);
        model_and_push();
    endtask

    // One full move: tick in IDLE, the MOVE cycle (optionally with a stray
    // tick), then three cooldown ticks with the buttons still held.
    task automatic do_move(input bit u, input bit d, input bit l, input bit rt,
                           input bit tick_in_move);
        step(0, 1, u, d, l, rt, $urandom_range(0, 127), $urandom_range(0, 127));
        step(0, tick_in_move, u, d, l, rt, $urandom_range(0, 127), $urandom_range(0, 127));
        for (int k = 0; k < CD; k++) begin
            step(0, 1, u, d, l, rt, $urandom_range(0, 127), $urandom_range(0, 127));
            step(0, 0, u, d, l, rt, $urandom_range(0, 127), $urandom_range(0, 127));
        end
    endtask

    task automatic settle();
        @(posedge my_clock);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge my_clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("oled_data", 32'(oled_data), 32'(e.oled));
                check("player_x", 32'(player_x), 32'(e.px));
                check("player_y", 32'(player_y), 32'(e.py));
                check("moving", 32'(moving), 32'(e.mv));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; move_tick = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        x = 7'd0; y = 7'd0;

        repeat (3) step(1, 0, 0, 0, 0, 0, 44, 28);
        step(1, 1, 1, 1, 1, 1, 44, 28);
        settle();
        check("reset_x", 32'(player_x), 32'(SX));
        check("reset_y", 32'(player_y), 32'(SY));
        check("reset_oled", 32'(oled_data), 32'h0);

        // Colour lookup: sprite, wall, background, off-screen and sprite edges.
        step(0, 0, 0, 0, 0, 0, 44, 28);
        step(0, 0, 0, 0, 0, 0, 0, 10);
        step(0, 0, 0, 0, 0, 0, 20, 20);
        step(0, 0, 0, 0, 0, 0, 100, 10);
        step(0, 0, 0, 0, 0, 0, 10, 70);
        step(0, 0, 0, 0, 0, 0, 51, 35);
        step(0, 0, 0, 0, 0, 0, 52, 28);
        step(0, 0, 0, 0, 0, 0, 43, 35);
        step(0, 0, 0, 0, 0, 0, 93, 61);
        step(0, 0, 0, 0, 0, 0, 94, 30);
        step(0, 0, 0, 0, 0, 0, 127, 127);
        step(0, 0, 0, 0, 0, 0, 44, 28);
        settle();
        check("oled_sprite_hit", 32'(oled_data), 32'hF800);

        // Buttons without a tick do nothing.
        repeat (4) step(0, 0, 1, 1, 1, 1, 20, 20);

        // Held right button with eight spaced ticks: two moves.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0, 1, $urandom_range(0, 127), $urandom_range(0, 127));
            step(0, 0, 0, 0, 0, 1, $urandom_range(0, 127), $urandom_range(0, 127));
        end
        settle();
        check("eight_ticks_x", 32'(player_x), 32'd46);
        check("eight_ticks_idle", 32'(moving), 32'd0);

        // Up beats left; tick during MOVE must not shorten the cooldown.
        do_move(1, 0, 1, 0, 1'b1);
        settle();
        check("priority_y", 32'(player_y), 32'd27);
        check("priority_x", 32'(player_x), 32'd46);

        // Walk right into the wall, then push against it once more.
        for (int i = 0; i < 42; i++) do_move(0, 0, 0, 1, i[0]);
        settle();
        check("clamp_right_x", 32'(player_x), 32'd86);
        step(0, 1, 0, 0, 0, 1, 20, 20);
        step(0, 0, 0, 0, 0, 1, 20, 20);
        settle();
        check("clamp_right_moving", 32'(moving), 32'd1);
        check("clamp_right_hold", 32'(player_x), 32'd86);
        for (int k = 0; k < CD; k++) begin
            step(0, 1, 0, 0, 0, 1, 20, 20);
            step(0, 0, 0, 0, 0, 1, 20, 20);
        end

        // Reset during the MOVE cycle discards the pending step.
        step(0, 1, 0, 0, 1, 0, 30, 30);
        step(1, 0, 0, 0, 1, 0, 30, 30);
        settle();
        check("reset_move_x", 32'(player_x), 32'(SX));
        check("reset_move_y", 32'(player_y), 32'(SY));
        check("reset_move_moving", 32'(moving), 32'd0);

        // Top and bottom clamps.
        for (int i = 0; i < 30; i++) do_move(1, 0, 0, 0, 1'b0);
        settle();
        check("clamp_up_y", 32'(player_y), 32'd2);
        for (int i = 0; i < 56; i++) do_move(0, 1, 0, 0, 1'b0);
        settle();
        check("clamp_down_y", 32'(player_y), 32'd54);

        // Randomised traffic, including occasional mid-cooldown resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 127), $urandom_range(0, 127));
        end

        settle();
        settle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
